// File: rtl/nlc_channel_scheduler.sv
// Round-robin scheduler sharing one NLC correction core between four ADC channels.
// Each channel has a one-deep hold register; results return with the channel index.
module nlc_channel_scheduler #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ch_srdyi,
  input  logic [83:0] ch_x_adc,
  output logic        core_srdyi,
  output logic [20:0] core_x_adc,
  input  logic        core_srdyo,
  input  logic [20:0] core_x_lin,
  output logic        out_srdyo,
  output logic [20:0] out_x_lin,
  output logic [1:0]  out_ch,
  output logic [3:0]  ovf,
  output logic [3:0]  to_err,
  input  logic        flag_clr,
  output logic        busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0][20:0] hold_q, hold_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       g_q, g_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             core_srdyi_q, core_srdyi_d;
  logic [20:0]      core_x_adc_q, core_x_adc_d;
  logic             out_srdyo_q, out_srdyo_d;
  logic [20:0]      out_x_lin_q, out_x_lin_d;
  logic [1:0]       out_ch_q, out_ch_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [3:0]       to_err_q, to_err_d;
  logic             busy_q, busy_d;

  logic [3:0][20:0] samp_s;
  logic [3:0]       rot_s;
  logic [1:0]       off_s;
  logic [1:0]       grant_s;
  logic [3:0]       issue_mask_s;
  logic [3:0]       ovf_set_s;
  logic [3:0]       tmo_set_s;

  // Grant: pend rotated so that rr_q sits at bit 0, then first set bit wins
  always_comb begin
    rot_s = pend_q;
    off_s = 2'd0;
    case (rr_q)
      2'd0:    rot_s = pend_q;
      2'd1:    rot_s = {pend_q[0],   pend_q[3:1]};
      2'd2:    rot_s = {pend_q[1:0], pend_q[3:2]};
      2'd3:    rot_s = {pend_q[2:0], pend_q[3]};
      default: rot_s = pend_q;
    endcase
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    grant_s = rr_q + off_s;
  end

  // Capture path, FSM next state and sticky flag update
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    g_d          = g_q;
    timer_d      = timer_q;
    core_srdyi_d = 1'b0;
    core_x_adc_d = core_x_adc_q;
    out_srdyo_d  = 1'b0;
    out_x_lin_d  = out_x_lin_q;
    out_ch_d     = out_ch_q;
    tmo_set_s    = 4'b0000;

    for (int i = 0; i < 4; i++) begin
      samp_s[i] = ch_x_adc[21*i +: 21];
      hold_d[i] = ch_srdyi[i] ? samp_s[i] : hold_q[i];
    end

    // A capture racing the issue of its own channel keeps pend and is not an overwrite
    issue_mask_s = (state_q == ISSUE) ? (4'b0001 << g_q) : 4'b0000;
    ovf_set_s    = ch_srdyi & pend_q & ~issue_mask_s;
    pend_d       = (pend_q & ~issue_mask_s) | ch_srdyi;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d      = ISSUE;
          g_d          = grant_s;
          core_srdyi_d = 1'b1;
          // hold is overwritten on this same edge, so forward the newest sample
          core_x_adc_d = ch_srdyi[grant_s] ? samp_s[grant_s] : hold_q[grant_s];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        if (core_srdyo) begin
          out_x_lin_d = core_x_lin;
          out_ch_d    = g_q;
          out_srdyo_d = 1'b1;
          rr_d        = g_q + 2'd1;
          state_d     = IDLE;
        end else if (timer_q == TMO_LAST) begin
          tmo_set_s = 4'b0001 << g_q;
          rr_d      = g_q + 2'd1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ovf_d    = (ovf_q    & ~{4{flag_clr}}) | ovf_set_s;
    to_err_d = (to_err_q & ~{4{flag_clr}}) | tmo_set_s;
    busy_d   = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= 4'b0000;
      hold_q       <= '0;
      rr_q         <= 2'd0;
      g_q          <= 2'd0;
      timer_q      <= '0;
      core_srdyi_q <= 1'b0;
      core_x_adc_q <= 21'd0;
      out_srdyo_q  <= 1'b0;
      out_x_lin_q  <= 21'd0;
      out_ch_q     <= 2'd0;
      ovf_q        <= 4'b0000;
      to_err_q     <= 4'b0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      rr_q         <= rr_d;
      g_q          <= g_d;
      timer_q      <= timer_d;
      core_srdyi_q <= core_srdyi_d;
      core_x_adc_q <= core_x_adc_d;
      out_srdyo_q  <= out_srdyo_d;
      out_x_lin_q  <= out_x_lin_d;
      out_ch_q     <= out_ch_d;
      ovf_q        <= ovf_d;
      to_err_q     <= to_err_d;
      busy_q       <= busy_d;
    end
  end

  assign core_srdyi = core_srdyi_q;
  assign core_x_adc = core_x_adc_q;
  assign out_srdyo  = out_srdyo_q;
  assign out_x_lin  = out_x_lin_q;
  assign out_ch     = out_ch_q;
  assign ovf        = ovf_q;
  assign to_err     = to_err_q;
  assign busy       = busy_q;

endmodule
